// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage issue controller for the multiply/divide unit.
// It decodes the E-stage MD op and drives start, op and operands to the MDU.
// A shadow busy FSM mirrors the MDU latency, including its freeze while req
// is high, and produces the D-stage stall for MD instructions. It also returns
// mfhi/mflo data to the E-stage forward mux.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req                 exception/interrupt flush (suppress issue, freeze countdown)
//   e_valid, e_op       E-stage valid and MD op
//   e_rs, e_rt          forwarded operands
//   d_is_md             D-stage instruction is an MD op
//   mdu_busy/hi/lo      status and results from the MDU
//   mdu_start/op/a/b    issue interface to the MDU
//   stall               stall D / freeze F / bubble into E
//   e_md_rdata          mfhi/mflo result
//   busy_shadow         internal busy model
// Optional (macro MDU_PROTO_CHECK_EN):
//   proto_err           sticky MDU protocol mismatch flag
//   mis_cnt             16-bit saturating mismatch cycle counter
module mdu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        stall,
  output logic [31:0] e_md_rdata,
  output logic        busy_shadow
`ifdef MDU_PROTO_CHECK_EN
  ,
  output logic        proto_err,
  output logic [15:0] mis_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_M = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               issue_ok;
  logic               op_known;
  logic               op_arith;
  logic               op_mul;

  // Issue qualification and op decode; 1001..1111 decode as no operation.
  assign issue_ok = e_valid && !req && (state == IDLE);
  assign op_known = (e_op >= 4'd1) && (e_op <= 4'd8);
  assign op_arith = (e_op >= 4'd1) && (e_op <= 4'd4);
  assign op_mul   = (e_op == 4'd1) || (e_op == 4'd2);

  assign mdu_start   = issue_ok && op_arith;
  assign mdu_op      = (issue_ok && op_known) ? e_op : 4'd0;
  assign mdu_a       = e_rs;
  assign mdu_b       = e_rt;
  assign busy_shadow = (state != IDLE);
  // mdu_busy is ORed in so a slow or mismatched MDU can never be overrun.
  assign stall       = d_is_md && (mdu_start || busy_shadow || mdu_busy);

  // HI/LO read-back; intentionally not gated by e_valid.
  always_comb begin
    e_md_rdata = 32'd0;
    if (e_op == 4'd5)      e_md_rdata = mdu_hi;
    else if (e_op == 4'd6) e_md_rdata = mdu_lo;
  end

  // Shadow busy FSM: counts down the MDU latency, frozen while req is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start) begin
            if (op_mul) begin
              state <= BUSY_M;
              cnt   <= CNT_W'(MULT_CYCLES - 1);
            end else begin
              state <= BUSY_D;
              cnt   <= CNT_W'(DIV_CYCLES - 1);
            end
          end
        end
        BUSY_M, BUSY_D: begin
          if (!req) begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef MDU_PROTO_CHECK_EN
  logic mismatch;

  // Busy disagreement, or an MD op reaching E while the unit is busy.
  assign mismatch = (mdu_busy != busy_shadow) ||
                    (e_valid && (e_op != 4'd0) && busy_shadow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
      mis_cnt   <= 16'd0;
    end else if (mismatch) begin
      proto_err <= 1'b1;
      if (mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: a driver applies directed and random
// cycles, predicts each cycle's outputs from a remaining-cycles busy model and
// queues them; a monitor pops and compares at every falling edge.
module tb_mdu_issue_ctrl;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  typedef struct packed {
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic [31:0] rdata;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        d_is_md = 1'b0;
  logic        mdu_busy = 1'b0;
  logic [31:0] mdu_hi = 32'd0;
  logic [31:0] mdu_lo = 32'd0;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        stall;
  logic [31:0] e_md_rdata;
  logic        busy_shadow;

  int   checks = 0;
  int   errors = 0;
  int   rem    = 0;   // req-free busy cycles still owed by the MDU
  exp_t sb_q[$];

  mdu_issue_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .e_valid    (e_valid),
    .e_op       (e_op),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .d_is_md    (d_is_md),
    .mdu_busy   (mdu_busy),
    .mdu_hi     (mdu_hi),
    .mdu_lo     (mdu_lo),
    .mdu_start  (mdu_start),
    .mdu_op     (mdu_op),
    .mdu_a      (mdu_a),
    .mdu_b      (mdu_b),
    .stall      (stall),
    .e_md_rdata (e_md_rdata),
    .busy_shadow(busy_shadow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whenever a prediction is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mdu_start",   32'(mdu_start),   32'(e.start));
        chk("mdu_op",      32'(mdu_op),      32'(e.op));
        chk("mdu_a",       mdu_a,            e.a);
        chk("mdu_b",       mdu_b,            e.b);
        chk("stall",       32'(stall),       32'(e.stall));
        chk("e_md_rdata",  e_md_rdata,       e.rdata);
        chk("busy_shadow", 32'(busy_shadow), 32'(e.busy));
      end
    end
  end

  // One cycle: drive inputs, optionally pulse reset mid-cycle, predict, advance model.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic dmd, input logic rq,
                     input logic mb, input logic [31:0] hi, input logic [31:0] lo,
                     input logic rst_now);
    exp_t e;
    logic busy, issue, arith;
    @(posedge clk);
    #1;
    if (!rst_now) reset = 1'b0;
    e_valid = v; e_op = op; e_rs = rs; e_rt = rt; d_is_md = dmd;
    req = rq; mdu_busy = mb; mdu_hi = hi; mdu_lo = lo;
    if (rst_now) begin
      #1;
      reset = 1'b1;
      rem   = 0;
    end
    busy    = (rem > 0);
    issue   = v && !rq && !busy;
    arith   = (op >= 4'd1) && (op <= 4'd4);
    e.start = issue && arith;
    e.op    = (issue && op >= 4'd1 && op <= 4'd8) ? op : 4'd0;
    e.a     = rs;
    e.b     = rt;
    e.busy  = busy;
    e.stall = dmd && (e.start || busy || mb);
    e.rdata = (op == 4'd5) ? hi : (op == 4'd6) ? lo : 32'd0;
    sb_q.push_back(e);
    if (!rst_now) begin
      if (rem > 0) begin
        if (!rq) rem--;
      end else if (e.start) begin
        rem = (op <= 4'd2) ? int'(MULT_CYCLES) : int'(DIV_CYCLES);
      end
    end
  endtask

  initial begin
    logic [3:0] rop;
    // Reset state.
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // mult 3*5, D-stage holds an MD op throughout.
    cyc(1'b1, 4'd1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // divu 100/7 then mflo once idle.
    cyc(1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd14, 1'b0);

    // div with a 3-cycle req freeze starting at cycle 4.
    cyc(1'b1, 4'd3, 32'd9, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 15; i++)
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, (i >= 4 && i <= 6), 1'b0, 32'd0, 32'd0, 1'b0);

    // mthi flushed by req, then issued normally (no busy).
    cyc(1'b1, 4'd7, 32'd11, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 4'd7, 32'd11, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reserved op, then an op presented while busy is not forwarded.
    cyc(1'b1, 4'd12, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 4'd2, 32'd7, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 4'd3, 32'd7, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Async reset mid-mult, then a fresh mult issues normally.
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b1, 4'd1, 32'd4, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      cyc(1'($urandom_range(0, 3) != 0), rop, $urandom, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 7) == 0), $urandom, $urandom,
          ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
E-stage initiator for the multiply/divide unit in the P7 pipeline. Decodes the E-stage MD operation and drives the MDU's start/op/operand inputs. Keeps a shadow busy FSM that mirrors MDU latency and freeze-on-exception behaviour, and uses it to produce the D-stage stall for MD instructions. Also returns mfhi/mflo data to the E-stage forward mux.

Parameters:
MULT_CYCLES, 5, cycles busy is high after a mult/multu start edge
DIV_CYCLES, 10, cycles busy is high after a div/divu start edge
CNT_W, 4, shadow counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  exception/interrupt flush; suppresses issue and freezes busy countdown
e_valid  in  1  E-stage instruction valid (not a bubble)
e_op  in  4  MD op: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo
e_rs  in  32  forwarded rs operand
e_rt  in  32  forwarded rt operand
d_is_md  in  1  D-stage instruction is any MD op (0001..1000)
mdu_busy  in  1  busy from MDU
mdu_hi  in  32  MDU HI
mdu_lo  in  32  MDU LO
mdu_start  out  1  start pulse to MDU
mdu_op  out  4  op to MDU
mdu_a  out  32  operand A (=e_rs)
mdu_b  out  32  operand B (=e_rt)
stall  out  1  stall D/freeze F, bubble into E
e_md_rdata  out  32  mfhi/mflo result
busy_shadow  out  1  internal busy model

Behaviour:
- Reset (async, immediate): state IDLE, cnt 0, busy_shadow 0. Combinational outputs then follow inputs: mdu_start 0 unless issuing; stall 0 unless d_is_md && mdu_start.
- issue_ok = e_valid && !req && state==IDLE.
- mdu_op = issue_ok ? e_op : 0000. With req high, always 0000, so no HI/LO write on a flushed instruction.
- mdu_start = issue_ok && e_op in {0001..0100}. Combinational, single cycle per instruction.
- mdu_a = e_rs, mdu_b = e_rt, unconditionally.
- FSM (posedge clk):
  - IDLE: on mult/multu start go BUSY_M, cnt=MULT_CYCLES-1; on div/divu start go BUSY_D, cnt=DIV_CYCLES-1.
  - BUSY_M/BUSY_D: if req, hold state and cnt (matches MDU freeze). Otherwise, if cnt==0 go IDLE, else cnt-1.
- busy_shadow = (state!=IDLE). It is high exactly MULT_CYCLES / DIV_CYCLES req-free cycles after the start edge.
- stall = d_is_md && (mdu_start || busy_shadow || mdu_busy). mdu_busy is ORed for safety.
- e_md_rdata = mdu_hi if e_op==0101, mdu_lo if 0110, else 0. Not gated by e_valid.
- Op presented while state!=IDLE (stall violated upstream): not forwarded (mdu_op 0000), no FSM change.
- e_op values 1001..1111: treated as none.
- Reset mid-BUSY: returns to IDLE immediately; stall drops in the same cycle.

Optional Feature:
MDU_PROTO_CHECK_EN: adds output proto_err (1 bit) and a 16-bit saturating mismatch counter, mis_cnt.
- proto_err is a sticky register, cleared only by reset.
- It sets on any cycle where mdu_busy != busy_shadow, or where e_valid && e_op!=0 while busy_shadow.
- mis_cnt increments on each such cycle.
- Without the macro, neither port nor logic exists and behaviour is otherwise identical.

Test Plan:
1. mult e_rs=3,e_rt=5 at cycle 0 → mdu_start=1, mdu_op=0001; busy_shadow high cycles 1-5, low at 6; d_is_md=1 during 0-5 → stall=1, stall=0 at 6.
2. divu 100/7 at cycle 0 with no req → busy_shadow high cycles 1-10; mflo at cycle 11 with mdu_lo=14 → e_md_rdata=14.
3. div issued, req high for 3 cycles at cycle 4 → busy_shadow stays high through cycle 13, low at 14.
4. mthi with req=1 → mdu_op=0000, mdu_start=0, FSM stays IDLE; same op with req=0 → mdu_op=0111, no busy.
5. Async reset asserted mid-mult (cnt=2) between edges → busy_shadow=0 and stall=0 immediately; next mult issues normally.
6. (MDU_PROTO_CHECK_EN) mdu_busy held 0 after a mult start → proto_err=1 from cycle 2; mis_cnt=5 after the busy window.
